// File: rtl/secded_codec_pkg.sv
// Shared definitions for the SEC-DED codec: op codes, decode classes and
// the Hamming layout helpers used to size and wire the datapath.
package secded_codec_pkg;

  typedef enum logic {
    OP_ENCODE = 1'b0,
    OP_DECODE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    CLS_CLEAN  = 2'd0,
    CLS_CORR   = 2'd1,
    CLS_UNCORR = 2'd2
  } cls_e;

  // Smallest r with 2**r >= data_w + r + 1.
  function automatic int secded_par_w(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < (data_w + r + 1)) r++;
    return r;
  endfunction

  function automatic bit secded_is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Hamming position (1-based) of data bit idx: data fills the
  // non-power-of-2 positions in increasing order, LSB first.
  function automatic int secded_data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    while (cnt < idx) begin
      pos++;
      if (!secded_is_pow2(pos)) cnt++;
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_codec_parity_tree.sv
// Combinational parity tree: bit k of the result is the XOR of every
// Hamming position whose index has bit k set. With zeros at the parity
// positions this yields the encode parity; on a received frame it yields
// the syndrome directly.
module secded_codec_parity_tree
  import secded_codec_pkg::*;
#(
  parameter  int DATA_W = 11,
  localparam int PAR_W  = secded_par_w(DATA_W),
  localparam int NPOS   = DATA_W + PAR_W
) (
  input  logic [NPOS-1:0]  pos_i,
  output logic [PAR_W-1:0] par_o
);

  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
    logic [NPOS-1:0] mask;
    // position gj+1 participates in check gi when that index bit is set
    for (genvar gj = 0; gj < NPOS; gj++) begin : g_pos
      assign mask[gj] = (((gj + 1) >> gi) & 1) != 0;
    end
    assign par_o[gi] = ^(pos_i & mask);
  end

endmodule

// File: rtl/secded_codec.sv
// Two-stage pipelined Hamming SEC-DED encoder/decoder with valid/ready
// flow control, saturating error counters and a sticky uncorrectable irq.
module secded_codec
  import secded_codec_pkg::*;
#(
  parameter  int DATA_W  = 11,
  parameter  int CNT_W   = 16,
  localparam int PAR_W   = secded_par_w(DATA_W),
  localparam int FRAME_W = DATA_W + PAR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_op,
  input  logic [DATA_W-1:0]  in_packet,
  input  logic [FRAME_W-1:0] in_frame,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_op,
  output logic [FRAME_W-1:0] out_codeword,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_corr,
  output logic               out_uncorr,
  output logic [CNT_W-1:0]   cnt_corr,
  output logic [CNT_W-1:0]   cnt_uncorr,
  input  logic               cnt_clr,
  output logic               irq,
  input  logic               irq_clr
);

  localparam int NPOS = FRAME_W - 1;
  localparam logic [PAR_W-1:0] MAX_SYN = PAR_W'(NPOS);
  localparam logic [NPOS-1:0]  NPOS_ONE = NPOS'(1);

  // Flow control
  logic s1_adv, in_fire, out_fire;

  // Stage 1 registers
  logic              s1_valid_q;
  logic              s1_op_q;
  logic [NPOS-1:0]   s1_pos_q;
  logic [PAR_W-1:0]  s1_par_q;
  logic              s1_o2_q;

  // Stage 2 registers (the visible result)
  logic               s2_valid_q;
  logic               s2_op_q;
  logic [FRAME_W-1:0] s2_codeword_q, s2_codeword_d;
  logic [DATA_W-1:0]  s2_data_q, s2_data_d;
  logic               s2_corr_q, s2_corr_d;
  logic               s2_uncorr_q, s2_uncorr_d;

  // Counters and irq
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;
  logic             irq_q, irq_d;

  // Datapath nets
  logic [NPOS-1:0]   enc_pos;
  logic [NPOS-1:0]   s1_pos_mux;
  logic [PAR_W-1:0]  s1_par;
  logic [NPOS-1:0]   enc_cw;
  logic [NPOS-1:0]   dec_pos;
  logic [DATA_W-1:0] dec_data;
  cls_e              cls;

  assign s1_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s2_valid_q && out_ready;

  // Scatter/gather between packet bits and Hamming positions
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
    localparam int P = secded_data_pos(gi) - 1;
    assign enc_pos[P]  = in_packet[gi];
    assign enc_cw[P]   = s1_pos_q[P];
    assign dec_data[gi] = dec_pos[P];
  end

  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_parpos
    localparam int P = (1 << gi) - 1;
    assign enc_pos[P] = 1'b0;
    assign enc_cw[P]  = s1_par_q[gi];
  end

  assign s1_pos_mux = (in_op == OP_ENCODE) ? enc_pos : in_frame[NPOS-1:0];

  secded_codec_parity_tree #(
    .DATA_W (DATA_W)
  ) u_parity_tree (
    .pos_i (s1_pos_mux),
    .par_o (s1_par)
  );

  // Classify the registered syndrome and apply the single-bit correction
  always_comb begin
    cls = CLS_CLEAN;
    if (s1_par_q > MAX_SYN)
      cls = CLS_UNCORR;
    else if (s1_o2_q)
      cls = CLS_CORR;
    else if (s1_par_q != '0)
      cls = CLS_UNCORR;
    dec_pos = s1_pos_q;
    if (cls == CLS_CORR && s1_par_q != '0)
      dec_pos = s1_pos_q ^ (NPOS_ONE << (s1_par_q - PAR_W'(1)));
  end

  // Build the stage-2 result; fields not belonging to the op read 0
  always_comb begin
    s2_codeword_d = '0;
    s2_data_d     = '0;
    s2_corr_d     = 1'b0;
    s2_uncorr_d   = 1'b0;
    if (s1_op_q == OP_ENCODE) begin
      s2_codeword_d = {^enc_cw, enc_cw};
    end else begin
      s2_data_d   = dec_data;
      s2_corr_d   = (cls == CLS_CORR);
      s2_uncorr_d = (cls == CLS_UNCORR);
    end
  end

  // Pipeline registers: S1 loads on input handshake, S2 on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= 1'b0;
      s1_pos_q      <= '0;
      s1_par_q      <= '0;
      s1_o2_q       <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_op_q       <= 1'b0;
      s2_codeword_q <= '0;
      s2_data_q     <= '0;
      s2_corr_q     <= 1'b0;
      s2_uncorr_q   <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_op_q  <= in_op;
        s1_pos_q <= s1_pos_mux;
        s1_par_q <= s1_par;
        s1_o2_q  <= ^in_frame;
      end
      if (s1_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_op_q       <= s1_op_q;
          s2_codeword_q <= s2_codeword_d;
          s2_data_q     <= s2_data_d;
          s2_corr_q     <= s2_corr_d;
          s2_uncorr_q   <= s2_uncorr_d;
        end
      end
    end
  end

  // Saturating counters (clear wins) and sticky irq (set wins)
  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    irq_d        = irq_q;
    if (cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else begin
      if (out_fire && s2_corr_q && cnt_corr_q != '1)
        cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (out_fire && s2_uncorr_q && cnt_uncorr_q != '1)
        cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
    end
    if (irq_clr) irq_d = 1'b0;
    if (out_fire && s2_uncorr_q) irq_d = 1'b1;
  end

  // Counter and irq state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
      irq_q        <= irq_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_op       = s2_op_q;
  assign out_codeword = s2_codeword_q;
  assign out_data     = s2_data_q;
  assign out_corr     = s2_corr_q;
  assign out_uncorr   = s2_uncorr_q;
  assign cnt_corr     = cnt_corr_q;
  assign cnt_uncorr   = cnt_uncorr_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_secded_codec.sv
// Self-checking bench for secded_codec (DATA_W=11, CNT_W=2 so saturation
// is reachable). Reference model works on Hamming indices directly.
module tb_secded_codec;
  import secded_codec_pkg::*;

  localparam int DW = 11;
  localparam int FW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_op = 1'b0;
  logic [DW-1:0] in_packet = '0;
  logic [FW-1:0] in_frame = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_op;
  logic [FW-1:0] out_codeword;
  logic [DW-1:0] out_data;
  logic          out_corr, out_uncorr;
  logic [CW-1:0] cnt_corr, cnt_uncorr;
  logic          cnt_clr = 1'b0;
  logic          irq;
  logic          irq_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  int exp_cc = 0;
  int exp_cu = 0;
  logic exp_irq = 1'b0;

  typedef struct {
    logic          op;
    logic [FW-1:0] cw;
    logic [DW-1:0] data;
    logic          corr;
    logic          uncorr;
  } res_t;

  secded_codec #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_packet(in_packet), .in_frame(in_frame),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_codeword(out_codeword), .out_data(out_data),
    .out_corr(out_corr), .out_uncorr(out_uncorr),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr), .cnt_clr(cnt_clr),
    .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  // Encode: place data at non-power-of-2 indices, then set parity bits so
  // the XOR of the indices of all set bits is zero; finally overall parity.
  function automatic logic [FW-1:0] ref_encode(input logic [DW-1:0] d);
    logic [FW-1:0] f;
    int idx, syn;
    f = '0; idx = 0; syn = 0;
    for (int p = 1; p < FW; p++)
      if ((p & (p - 1)) != 0) begin f[p-1] = d[idx]; idx++; end
    for (int p = 1; p < FW; p++) if (f[p-1]) syn = syn ^ p;
    for (int k = 0; k < 4; k++) if (((syn >> k) & 1) != 0) f[(1 << k) - 1] = 1'b1;
    f[FW-1] = ^f[FW-2:0];
    return f;
  endfunction

  function automatic res_t ref_decode(input logic [FW-1:0] fin);
    res_t r;
    logic [FW-1:0] f;
    int syn, idx;
    logic o2;
    f = fin; syn = 0;
    for (int p = 1; p < FW; p++) if (f[p-1]) syn = syn ^ p;
    o2 = ^f;
    r.op = OP_DECODE; r.cw = '0; r.corr = 1'b0; r.uncorr = 1'b0;
    if (o2) begin
      r.corr = 1'b1;
      if (syn != 0) f[syn-1] = ~f[syn-1];
    end else if (syn != 0) begin
      r.uncorr = 1'b1;
    end
    idx = 0; r.data = '0;
    for (int p = 1; p < FW; p++)
      if ((p & (p - 1)) != 0) begin r.data[idx] = f[p-1]; idx++; end
    return r;
  endfunction

  function automatic res_t ref_result(input logic op, input logic [DW-1:0] d, input logic [FW-1:0] f);
    res_t r;
    if (op == OP_ENCODE) begin
      r.op = OP_ENCODE; r.cw = ref_encode(d); r.data = '0; r.corr = 1'b0; r.uncorr = 1'b0;
    end else r = ref_decode(f);
    return r;
  endfunction

  // Model update for an accepted result, with optional clears that cycle.
  task automatic model_accept(input res_t e, input logic clr_irq, input logic clr_cnt);
    if (clr_cnt) begin exp_cc = 0; exp_cu = 0; end
    else begin
      if (e.corr && exp_cc < 3) exp_cc++;
      if (e.uncorr && exp_cu < 3) exp_cu++;
    end
    if (clr_irq) exp_irq = 1'b0;
    if (e.uncorr) exp_irq = 1'b1;
  endtask

  function automatic logic [FW-1:0] flip_bits(input logic [FW-1:0] f, input int n);
    logic [FW-1:0] g;
    int a, b;
    g = f;
    a = $urandom_range(0, FW - 1);
    b = (a + $urandom_range(1, FW - 1)) % FW;
    if (n >= 1) g[a] = ~g[a];
    if (n >= 2) g[b] = ~g[b];
    return g;
  endfunction

  // One transaction through an empty pipeline with out_ready held high.
  // Called and returns at #1 after a rising edge.
  task automatic run_one(input logic op, input logic [DW-1:0] pkt, input logic [FW-1:0] frm,
                         input logic clr_irq, input logic clr_cnt,
                         output res_t r, output int lat);
    in_op = op; in_packet = pkt; in_frame = frm; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r.op = out_op; r.cw = out_codeword; r.data = out_data;
    r.corr = out_corr; r.uncorr = out_uncorr;
    irq_clr = clr_irq; cnt_clr = clr_cnt;
    @(posedge clk); #1;
    irq_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (cnt_corr !== 2'd0 || cnt_uncorr !== 2'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", cnt_corr, cnt_uncorr); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    $display("reset: done");
  endtask

  task automatic test_encode();
    logic [DW-1:0] vin [6];
    logic [FW-1:0] vexp [6];
    res_t r; int lat;
    vin[0] = 11'h001; vexp[0] = 16'h8007;
    vin[1] = 11'h7FF; vexp[1] = 16'hFFFF;
    vin[2] = 11'h000; vexp[2] = 16'h0000;
    for (int i = 3; i < 6; i++) begin vin[i] = 11'($urandom_range(0, 2047)); vexp[i] = ref_encode(vin[i]); end
    for (int i = 0; i < 6; i++) begin
      run_one(OP_ENCODE, vin[i], 16'($urandom), 1'b0, 1'b0, r, lat);
      $display("encode: pkt=%h cw=%h lat=%0d", vin[i], r.cw, lat);
      checks++; if (r.cw !== vexp[i]) begin errors++; $display("FAIL encode_cw pkt=%h got=%h want=%h", vin[i], r.cw, vexp[i]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL encode_latency got=%0d want=2", lat); end
      checks++; if (r.data !== '0 || r.corr !== 1'b0 || r.uncorr !== 1'b0 || r.op !== OP_ENCODE) begin
        errors++; $display("FAIL encode_side got data=%h corr=%b uncorr=%b op=%b want 0/0/0/0", r.data, r.corr, r.uncorr, r.op); end
    end
  endtask

  task automatic test_decode_corr();
    logic [FW-1:0] fr [6];
    res_t r, e; int lat;
    logic [DW-1:0] d;
    fr[0] = 16'h8003; fr[1] = 16'h7FFF;
    for (int i = 2; i < 5; i++) begin d = 11'($urandom_range(0, 2047)); fr[i] = flip_bits(ref_encode(d), 1); end
    fr[5] = ref_encode(11'($urandom_range(0, 2047)));
    for (int i = 0; i < 6; i++) begin
      e = ref_decode(fr[i]);
      if (i == 0) e.data = 11'h001;
      if (i == 1) e.data = 11'h7FF;
      run_one(OP_DECODE, 11'($urandom), fr[i], 1'b0, 1'b0, r, lat);
      model_accept(e, 1'b0, 1'b0);
      $display("decode: frame=%h data=%h corr=%b uncorr=%b cnt_corr=%0d", fr[i], r.data, r.corr, r.uncorr, cnt_corr);
      checks++; if (r.data !== e.data) begin errors++; $display("FAIL decode_data frame=%h got=%h want=%h", fr[i], r.data, e.data); end
      checks++; if (r.corr !== e.corr || r.uncorr !== e.uncorr || r.cw !== '0 || r.op !== OP_DECODE) begin
        errors++; $display("FAIL decode_flags frame=%h got corr=%b uncorr=%b cw=%h want %b/%b/0", fr[i], r.corr, r.uncorr, r.cw, e.corr, e.uncorr); end
      checks++; if (cnt_corr !== CW'(exp_cc)) begin errors++; $display("FAIL decode_cnt_corr got=%0d want=%0d", cnt_corr, exp_cc); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL decode_latency got=%0d want=2", lat); end
    end
  endtask

  task automatic test_uncorr();
    res_t r, e; int lat;
    logic [FW-1:0] f;
    run_one(OP_DECODE, '0, 16'hFFFC, 1'b0, 1'b0, r, lat);
    model_accept(ref_decode(16'hFFFC), 1'b0, 1'b0);
    $display("uncorr: frame=fffc data=%h uncorr=%b irq=%b cnt_uncorr=%0d", r.data, r.uncorr, irq, cnt_uncorr);
    checks++; if (r.uncorr !== 1'b1 || r.corr !== 1'b0 || r.data !== 11'h7FF) begin
      errors++; $display("FAIL uncorr_fffc got uncorr=%b corr=%b data=%h want 1/0/7ff", r.uncorr, r.corr, r.data); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL uncorr_irq got=%b want=1", irq); end
    checks++; if (cnt_uncorr !== 2'd1) begin errors++; $display("FAIL uncorr_cnt got=%0d want=1", cnt_uncorr); end
    f = flip_bits(ref_encode(11'($urandom_range(0, 2047))), 2);
    e = ref_decode(f);
    run_one(OP_DECODE, '0, f, 1'b1, 1'b0, r, lat);
    model_accept(e, 1'b1, 1'b0);
    $display("uncorr: frame=%h with irq_clr irq=%b", f, irq);
    checks++; if (r.uncorr !== 1'b1 || r.data !== e.data) begin errors++; $display("FAIL uncorr_random got uncorr=%b data=%h want 1/%h", r.uncorr, r.data, e.data); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got=%b want=1", irq); end
    checks++; if (cnt_uncorr !== CW'(exp_cu)) begin errors++; $display("FAIL uncorr_cnt2 got=%0d want=%0d", cnt_uncorr, exp_cu); end
    irq_clr = 1'b1; @(posedge clk); #1; irq_clr = 1'b0; exp_irq = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got=%b want=0", irq); end
  endtask

  task automatic test_saturation();
    res_t r; int lat;
    logic [FW-1:0] f;
    cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0; exp_cc = 0; exp_cu = 0;
    checks++; if (cnt_corr !== 2'd0 || cnt_uncorr !== 2'd0) begin errors++; $display("FAIL cnt_clr got=%0d/%0d want=0/0", cnt_corr, cnt_uncorr); end
    for (int i = 0; i < 5; i++) begin
      f = flip_bits(ref_encode(11'($urandom_range(0, 2047))), 1);
      run_one(OP_DECODE, '0, f, 1'b0, 1'b0, r, lat);
      model_accept(ref_decode(f), 1'b0, 1'b0);
      $display("saturate: step=%0d cnt_corr=%0d", i, cnt_corr);
      checks++; if (cnt_corr !== CW'(exp_cc)) begin errors++; $display("FAIL sat_cnt step=%0d got=%0d want=%0d", i, cnt_corr, exp_cc); end
    end
    f = flip_bits(ref_encode(11'($urandom_range(0, 2047))), 1);
    run_one(OP_DECODE, '0, f, 1'b0, 1'b1, r, lat);
    model_accept(ref_decode(f), 1'b0, 1'b1);
    $display("saturate: clear with increment cnt_corr=%0d", cnt_corr);
    checks++; if (cnt_corr !== 2'd0) begin errors++; $display("FAIL clr_wins got=%0d want=0", cnt_corr); end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    int sent = 0, got = 0;
    fork
      begin : driver
        int guard = 0;
        logic pending = 1'b0;
        logic op; logic [DW-1:0] d; logic [FW-1:0] f;
        @(posedge clk); #2;
        while (sent < 8 && guard < 300) begin
          if (!pending) begin
            op = 1'($urandom_range(0, 1));
            d = 11'($urandom_range(0, 2047));
            f = flip_bits(ref_encode(11'($urandom_range(0, 2047))), $urandom_range(0, 2));
            in_op = op; in_packet = d; in_frame = f; in_valid = 1'b1; pending = 1'b1;
          end
          if (in_ready) begin q.push_back(ref_result(op, d, f)); sent++; pending = 1'b0; end
          @(posedge clk); #2; guard++;
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int guard = 0;
        logic stalled = 1'b0;
        res_t held, e;
        @(posedge clk); #1;
        while (got < 8 && guard < 400) begin
          if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_codeword !== held.cw || out_data !== held.data ||
                out_corr !== held.corr || out_uncorr !== held.uncorr || out_op !== held.op) begin
              errors++; $display("FAIL stall_stable got v=%b cw=%h d=%h want v=1 cw=%h d=%h", out_valid, out_codeword, out_data, held.cw, held.data);
            end
          end
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL stream_spurious got result with empty queue"); end
            else begin
              e = q.pop_front();
              $display("stream: #%0d op=%b cw=%h data=%h corr=%b uncorr=%b", got, out_op, out_codeword, out_data, out_corr, out_uncorr);
              if (out_op !== e.op || out_codeword !== e.cw || out_data !== e.data || out_corr !== e.corr || out_uncorr !== e.uncorr) begin
                errors++; $display("FAIL stream_result #%0d got op=%b cw=%h d=%h c=%b u=%b want op=%b cw=%h d=%h c=%b u=%b",
                  got, out_op, out_codeword, out_data, out_corr, out_uncorr, e.op, e.cw, e.data, e.corr, e.uncorr);
              end
              model_accept(e, 1'b0, 1'b0);
            end
            got++;
          end
          stalled = out_valid && !out_ready;
          held.op = out_op; held.cw = out_codeword; held.data = out_data;
          held.corr = out_corr; held.uncorr = out_uncorr;
          @(posedge clk); #1; guard++;
        end
      end
    join
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got !== 8 || sent !== 8) begin errors++; $display("FAIL stream_count got=%0d sent=%0d want=8/8", got, sent); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_duplicate out_valid=%b want=0", out_valid); end
    checks++; if (cnt_corr !== CW'(exp_cc) || cnt_uncorr !== CW'(exp_cu) || irq !== exp_irq) begin
      errors++; $display("FAIL stream_counters got=%0d/%0d irq=%b want=%0d/%0d irq=%b", cnt_corr, cnt_uncorr, irq, exp_cc, exp_cu, exp_irq); end
  endtask

  task automatic test_reset_flush();
    res_t r; int lat;
    run_one(OP_DECODE, '0, 16'hFFFC, 1'b0, 1'b0, r, lat);
    out_ready = 1'b0;
    in_op = OP_ENCODE; in_packet = 11'h123; in_valid = 1'b1;
    @(posedge clk); #1;
    in_packet = 11'h456;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_full got v=%b rdy=%b want 1/0", out_valid, in_ready); end
    #2 rst = 1'b1;
    #1;
    $display("flush: rst asserted v=%b cnt=%0d/%0d irq=%b", out_valid, cnt_corr, cnt_uncorr, irq);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    checks++; if (cnt_corr !== 2'd0 || cnt_uncorr !== 2'd0 || irq !== 1'b0) begin errors++; $display("FAIL flush_state got=%0d/%0d irq=%b want 0/0/0", cnt_corr, cnt_uncorr, irq); end
    exp_cc = 0; exp_cu = 0; exp_irq = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_stale cycle=%0d v=%b rdy=%b want 0/1", i, out_valid, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_decode_corr();
    test_uncorr();
    test_saturation();
    test_back_to_back();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
